// File: rtl/symbol_rate_nco.sv
// Symbol-rate NCO: debounces the byte-written 64-bit phase increment, runs the
// phase accumulator and turns accumulator wraps into credit-buffered symbol requests.
module symbol_rate_nco #(
    parameter int STABLE_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rstin,
    input  logic [63:0] srate,
    input  logic        enable,
    input  logic        sym_ready,
    input  logic        clear_ovr,
    output logic        sym_req,
    output logic [15:0] phase,
    output logic        rate_update,
    output logic        rate_locked,
    output logic        overrun
);
    localparam int               CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    state_t           state, state_nx;
    logic [63:0]      acc, acc_nx, inc_r, srate_q;
    logic [CNT_W-1:0] stab_cnt;
    logic [1:0]       pending, pending_nx;
    logic [64:0]      sum;
    logic             wrap, accept, adopt, ovr_set;

    assign rate_locked = (inc_r != '0);

    always_comb begin
        sum        = {1'b0, acc} + {1'b0, inc_r};
        wrap       = (state == RUN) && sum[64];
        accept     = sym_req && sym_ready;
        // Adoption never touches acc, so the phase stays continuous across rate changes.
        adopt      = (stab_cnt == CNT_MAX) && (srate_q != inc_r);
        state_nx   = state;
        acc_nx     = acc;
        pending_nx = pending;
        ovr_set    = 1'b0;

        case (state)
            IDLE: begin
                acc_nx = '0;
                if (enable) state_nx = RUN;
            end
            RUN: begin
                acc_nx = sum[63:0];
                if (!enable) state_nx = FLUSH;
            end
            FLUSH: begin
                if (enable) begin
                    state_nx = RUN;
                end else if (pending == 2'd0) begin
                    state_nx = IDLE;
                    acc_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state == IDLE) begin
            pending_nx = 2'd0;
        end else if (wrap && !accept) begin
            if (pending == 2'd3) ovr_set = 1'b1;
            else                 pending_nx = pending + 2'd1;
        end else if (!wrap && accept) begin
            pending_nx = pending - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstin) begin
            srate_q     <= '0;
            stab_cnt    <= '0;
            inc_r       <= '0;
            rate_update <= 1'b0;
            state       <= IDLE;
            acc         <= '0;
            phase       <= '0;
            pending     <= 2'd0;
            sym_req     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            srate_q     <= srate;
            stab_cnt    <= (srate != srate_q) ? '0 : sat_inc_cnt(stab_cnt);
            rate_update <= adopt;
            if (adopt) inc_r <= srate_q;
            state       <= state_nx;
            acc         <= acc_nx;
            phase       <= acc_nx[63:48];
            pending     <= pending_nx;
            sym_req     <= (pending_nx != 2'd0);
            // A lost wrap in the same cycle as a clear still leaves the flag set.
            overrun     <= ovr_set | (overrun & ~clear_ovr);
        end
    end
endmodule

// File: tb/tb_symbol_rate_nco.sv
// Directed bench for symbol_rate_nco: rate debounce, accumulator stepping,
// credit/overrun behaviour, flush/drain and reset.
module tb_symbol_rate_nco;
    logic        clk = 1'b0;
    logic        rstin, enable, sym_ready, clear_ovr;
    logic [63:0] srate;
    logic        sym_req, rate_update, rate_locked, overrun;
    logic [15:0] phase;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    symbol_rate_nco #(.STABLE_CYCLES(256)) dut (
        .clk(clk), .rstin(rstin), .srate(srate), .enable(enable),
        .sym_ready(sym_ready), .clear_ovr(clear_ovr), .sym_req(sym_req),
        .phase(phase), .rate_update(rate_update), .rate_locked(rate_locked),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expects one rate_update pulse exactly exp_edges edges from now, one cycle wide.
    task automatic wait_pulse(input string tag, input int exp_edges);
        int k;
        k = 0;
        for (int i = 1; i <= exp_edges + 50; i++) begin
            step(1);
            if (rate_update === 1'b1) begin
                k = i;
                break;
            end
        end
        chk({tag, "_edge"}, k, exp_edges);
        step(1);
        chk({tag, "_width"}, rate_update, 1'b0);
    endtask

    task automatic drain_sb(input string tag);
        logic [16:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step(1);
            chk({tag, "_phase"}, phase, e[15:0]);
            chk({tag, "_req"}, sym_req, e[16]);
        end
    endtask

    initial begin
        logic [63:0] fin;
        logic [63:0] prod;
        int          spurious, pulses, pulse_at, seen;

        // 1: reset values and first adoption
        rstin = 1'b1; enable = 1'b1; sym_ready = 1'b0; clear_ovr = 1'b0;
        srate = 64'h1234;
        step(2);
        chk("rst_req", sym_req, 1'b0);
        chk("rst_phase", phase, 16'h0);
        chk("rst_upd", rate_update, 1'b0);
        chk("rst_lock", rate_locked, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        rstin = 1'b0; enable = 1'b0;
        wait_pulse("t1_upd", 257);
        chk("t1_lock", rate_locked, 1'b1);

        // 2: steady rate 2^62 -> one request every 4 cycles
        srate = 64'h4000_0000_0000_0000;
        wait_pulse("t2_upd", 257);
        enable = 1'b1; sym_ready = 1'b1;
        exp_q.push_back({1'b0, 16'h0000});
        for (int k = 2; k <= 16; k++)
            exp_q.push_back({((k - 1) % 4) == 0, 16'((k - 1) % 4) * 16'h4000});
        drain_sb("t2");
        chk("t2_ovr", overrun, 1'b0);

        // 3: byte-wise update, then verify the adopted increment through phase
        enable = 1'b0;
        fin = 64'h0811_2233_4455_6677;
        spurious = 0; pulses = 0; pulse_at = 0;
        for (int b = 0; b < 8; b++) begin
            srate[8*b +: 8] = fin[8*b +: 8];
            for (int j = 1; j <= ((b == 7) ? 320 : 100); j++) begin
                step(1);
                if (rate_update === 1'b1) begin
                    if (b < 7) spurious++;
                    else begin
                        pulses++;
                        if (pulse_at == 0) pulse_at = j;
                    end
                end
            end
        end
        chk("t3_spurious", spurious, 0);
        chk("t3_pulses", pulses, 1);
        chk("t3_edge", pulse_at, 257);
        enable = 1'b1;
        exp_q.push_back({1'b0, 16'h0000});
        for (int k = 2; k <= 8; k++) begin
            prod = fin * 64'(k - 1);
            exp_q.push_back({1'b0, prod[63:48]});
        end
        drain_sb("t3");

        // 4: backpressure with 2^63
        enable = 1'b0; sym_ready = 1'b1;
        step(4);
        srate = 64'h8000_0000_0000_0000;
        wait_pulse("t4_upd", 257);
        sym_ready = 1'b0; enable = 1'b1;
        step(2);
        chk("t4_phase", phase, 16'h8000);
        step(1);
        chk("t4_req1", sym_req, 1'b1);
        step(5);
        chk("t4_ovr_pre", overrun, 1'b0);
        step(1);
        chk("t4_ovr_set", overrun, 1'b1);
        clear_ovr = 1'b1;
        step(1);
        chk("t4_ovr_clr", overrun, 1'b0);
        clear_ovr = 1'b0; sym_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (overrun !== 1'b0) seen++;
        end
        chk("t4_no_ovr", seen, 0);
        enable = 1'b0;
        step(8);
        chk("t4_idle_phase", phase, 16'h0);
        chk("t4_idle_req", sym_req, 1'b0);

        // 5: drain with two pending, then re-enable during FLUSH
        sym_ready = 1'b0; enable = 1'b1;
        step(5);
        chk("t5_p2_req", sym_req, 1'b1);
        chk("t5_p2_phase", phase, 16'h0);
        enable = 1'b0;
        step(1);
        chk("t5_flush_phase", phase, 16'h8000);
        step(3);
        chk("t5_hold_phase", phase, 16'h8000);
        chk("t5_hold_req", sym_req, 1'b1);
        sym_ready = 1'b1;
        step(1);
        chk("t5_acc1_req", sym_req, 1'b1);
        step(1);
        chk("t5_acc2_req", sym_req, 1'b0);
        chk("t5_acc2_phase", phase, 16'h8000);
        step(1);
        chk("t5_idle_phase", phase, 16'h0);
        sym_ready = 1'b0; enable = 1'b1;
        step(1);
        enable = 1'b0;
        step(1);
        chk("t5_re_flush", phase, 16'h8000);
        enable = 1'b1;
        step(1);
        chk("t5_re_hold", phase, 16'h8000);
        step(1);
        chk("t5_re_wrap_phase", phase, 16'h0);
        chk("t5_re_wrap_req", sym_req, 1'b1);

        // 6: mid-run reset with three pending, then zero rate
        step(4);
        chk("t6_p3_req", sym_req, 1'b1);
        rstin = 1'b1;
        step(1);
        chk("t6_rst_req", sym_req, 1'b0);
        chk("t6_rst_phase", phase, 16'h0);
        chk("t6_rst_upd", rate_update, 1'b0);
        chk("t6_rst_lock", rate_locked, 1'b0);
        rstin = 1'b0; enable = 1'b0;
        wait_pulse("t6_upd_nz", 257);
        chk("t6_lock_nz", rate_locked, 1'b1);
        srate = 64'h0;
        wait_pulse("t6_upd_zero", 257);
        chk("t6_lock_zero", rate_locked, 1'b0);
        enable = 1'b1; sym_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (sym_req !== 1'b0 || phase !== 16'h0) seen++;
        end
        chk("t6_zero_idle", seen, 0);
        chk("t6_zero_ovr", overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
